// File: rtl/gemm_result_collector.sv
// Result collector for the fixed-weights GEMM wrapper: buffers de-skewed output rows
// in a first-word-fall-through FIFO and replays them on a valid/ready stream with tile framing.
module gemm_result_collector #(
  parameter int SA_SIZE                = 4,
  parameter int WEIGHT_ACTIVATION_SIZE = 8,
  parameter int DEPTH                  = 8,
  parameter int TILE_ROWS              = 4
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [WEIGHT_ACTIVATION_SIZE-1:0] in_data [SA_SIZE],
  input  logic                              in_valid,
  input  logic                              capture_en,
  input  logic                              clear_status,
  output logic [WEIGHT_ACTIVATION_SIZE-1:0] out_data [SA_SIZE],
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic [$clog2(DEPTH+1)-1:0]        fifo_count,
  output logic                              overflow,
  output logic [15:0]                       drop_count
);

  localparam int W  = WEIGHT_ACTIVATION_SIZE;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int RW = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;

  logic [W-1:0]  mem_data_q [DEPTH][SA_SIZE];
  logic [W-1:0]  mem_data_d [DEPTH][SA_SIZE];
  logic          mem_last_q [DEPTH];
  logic          mem_last_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [RW-1:0] row_idx_q, row_idx_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_count_q, drop_count_d;

  logic offer, pop, push, drop, last_tag;

  always_comb begin
    offer    = in_valid && capture_en;
    pop      = (count_q != '0) && out_ready;
    push     = offer && ((count_q < CW'(DEPTH)) || pop);
    drop     = offer && !push;
    last_tag = (row_idx_q == RW'(TILE_ROWS-1));

    mem_data_d   = mem_data_q;
    mem_last_d   = mem_last_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    row_idx_d    = row_idx_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;

    if (push) begin
      mem_data_d[wr_ptr_q] = in_data;
      mem_last_d[wr_ptr_q] = last_tag;
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    // Framing follows the array stream, so dropped rows still advance the index.
    if (offer) begin
      row_idx_d = last_tag ? '0 : row_idx_q + 1'b1;
    end

    if (clear_status) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (clear_status) begin
        drop_count_d = 16'd1;
      end else if (drop_count_q != 16'hFFFF) begin
        drop_count_d = drop_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      row_idx_q    <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      row_idx_q    <= row_idx_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Row storage needs no reset; the head is only meaningful while out_valid is high.
  always_ff @(posedge clk) begin
    mem_data_q <= mem_data_d;
    mem_last_q <= mem_last_d;
  end

  always_comb begin
    out_data   = mem_data_q[rd_ptr_q];
    out_valid  = (count_q != '0);
    out_last   = out_valid && mem_last_q[rd_ptr_q];
    fifo_count = count_q;
    overflow   = overflow_q;
    drop_count = drop_count_q;
  end

endmodule

// File: doc/gemm_result_collector.md
Name: gemm_result_collector

Overview:
- Downstream stage of the fixed-weights GEMM wrapper.
- Captures the de-skewed activation-output vector the wrapper emits every cycle once its output-valid flag rises, and buffers it in a first-word-fall-through FIFO.
- Re-emits the buffered rows on a valid/ready stream, tagging the last row of each tile, so consumers can apply backpressure the systolic array cannot honour.
- Reports overflow and dropped rows as status.

Parameters:
SA_SIZE, 4, vector length (array dimension)
WEIGHT_ACTIVATION_SIZE, 8, bits per vector element
DEPTH, 8, FIFO depth in rows, integer >= 2 (not required power of 2)
TILE_ROWS, 4, rows per tile for out_last framing, >= 1

Ports:
clk  input  1  clock
resetn  input  1  synchronous active-low reset
in_data  input  [WEIGHT_ACTIVATION_SIZE-1:0] x SA_SIZE (unpacked array)  row from GEMM activation outputs
in_valid  input  1  GEMM output-valid flag (level)
capture_en  input  1  software gate; a row is offered only when in_valid && capture_en
clear_status  input  1  one-cycle pulse clearing overflow and drop_count
out_data  output  [WEIGHT_ACTIVATION_SIZE-1:0] x SA_SIZE  FIFO head row
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts head when out_valid && out_ready
out_last  output  1  head row is the last row of a tile
fifo_count  output  $clog2(DEPTH+1)  rows currently stored
overflow  output  1  sticky: at least one row dropped
drop_count  output  16  dropped rows, saturating at 16'hFFFF

Behaviour:
- Reset: synchronous, active-low; clk drives all state.
- On reset, next edge sets all of the following to zero:
  - write/read pointers, fifo_count, row index, overflow, drop_count
  - out_valid=0, out_last=0
- out_data after reset is don't-care while out_valid=0.
- Reset mid-operation discards all stored rows and restarts tile framing at row 0.
- offer = in_valid && capture_en; pop = out_valid && out_ready.
- Storage per entry: SA_SIZE elements plus a last bit.
- Push accepted when offer && (fifo_count<DEPTH || pop).
  - Simultaneous push and pop at full is allowed; fifo_count stays DEPTH.
- Drop when offer && fifo_count==DEPTH && !pop.
  - Row is discarded, overflow<=1, drop_count increments unless already 16'hFFFF.
- Pop when empty cannot occur (out_valid=0); out_ready is ignored while empty.
- fifo_count next value:
  - +1 on push only
  - -1 on pop only
  - unchanged on both or neither
- Pointers wrap from DEPTH-1 to 0.
- Latency: a row pushed at edge t appears on out_data with out_valid=1 in the cycle after t, when the FIFO was empty. FIFO-through latency is 1 cycle; there is no combinational in-to-out path.
- out_data, out_last and out_valid are driven from registered state only. They must remain stable while out_valid && !out_ready.
- Tile framing:
  - Row index counts 0..TILE_ROWS-1 and advances on every offer, accepted or dropped, so framing stays aligned to the array stream.
  - Stored last bit = (row index == TILE_ROWS-1); the index then wraps to 0.
  - With TILE_ROWS=1 every row is last.
  - A dropped last row loses its tag; overflow signals the misframing.
- capture_en low: rows are neither stored nor counted; row index holds.
- clear_status:
  - Sets overflow<=0 and drop_count<=0.
  - If a drop occurs in the same cycle, the drop wins: overflow=1, drop_count=1.
  - Does not touch FIFO contents or row index.
- Element values pass through unmodified; no arithmetic on data.

Test Plan:
- Reset then drive in_valid=1, capture_en=1, out_ready=1, rows {1,2,3,4},{5,6,7,8},... -> out_valid rises 1 cycle after the first push, rows appear in order, out_last=1 on every 4th row, fifo_count stays <=1.
- out_ready=0, offer 8 rows -> fifo_count=8, overflow=0. Offer 3 more -> overflow=1, drop_count=3, fifo_count=8. Release out_ready -> exactly the first 8 rows drain, then out_valid=0.
- Full FIFO with out_ready=1 and a simultaneous offer -> push accepted, fifo_count stays 8, no drop.
- drop_count preloaded by 65540 drops -> holds 16'hFFFF. clear_status pulse alone -> both zero. clear_status coincident with a drop -> overflow=1, drop_count=1.
- capture_en toggled 1,0,1 across 5 valid cycles -> only the 4 gated-in rows are stored, and the last tag lands on the 4th stored row.
- Assert resetn=0 with 5 rows stored -> next cycle fifo_count=0, out_valid=0, overflow=0. The first row after reset is tagged as tile row 0.
